// File: rtl/speed_ctrl_pkg.sv
// Shared encodings for the speed controller: FSM states, speed codes, step helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package speed_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEBOUNCE  = 3'd1,
        ST_WAIT_EDGE = 3'd2,
        ST_APPLY     = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

    localparam logic [1:0] SPD_NORMAL = 2'd0;
    localparam logic [1:0] SPD_FAST0  = 2'd1;
    localparam logic [1:0] SPD_FAST1  = 2'd2;

    // One saturating step up or down; never produces the unused code 3.
    function automatic logic [1:0] next_speed(input logic [1:0] cur, input logic up);
        if (up) begin
            return (cur == SPD_NORMAL) ? SPD_FAST0 : SPD_FAST1;
        end else begin
            return (cur == SPD_FAST1) ? SPD_FAST0 : SPD_NORMAL;
        end
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level into the i_clk domain.
// Latency: 2 i_clk cycles.
// Backpressure: none; samples every cycle.
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the raw level through two flops to settle metastability.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/speed_ctrl.sv
// Debounced up/down speed selector; changes are applied on a divider falling edge.
// Latency: 2 sync + DEBOUNCE_CYC debounce + wait for div_clk fall (bounded by WAIT_MAX).
// Backpressure: buttons are ignored while a change is pending; held buttons never repeat.
// Optional feature macro: SPEED_CTRL_AUTO_RETURN_EN (auto-return to normal speed when idle).
module speed_ctrl
    import speed_ctrl_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd500_000,
    parameter logic [25:0] WAIT_MAX     = 26'd200_000,
    parameter logic [15:0] RETURN_EDGES = 16'd2000
) (
    input  logic       clkin,
    input  logic       rst_N,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       div_clk,
    output logic [1:0] fast,
    output logic       chg_pend
);

    logic        w_up;
    logic        w_dn;
    logic        w_div;
    logic        w_div_fall;
    logic        w_btn_lat;
    logic [1:0]  w_tgt_calc;

    state_t      r_state;
    logic        r_dir;
    logic [19:0] r_cnt;
    logic [25:0] r_wait;
    logic [1:0]  r_target;
    logic [1:0]  r_fast;
    logic        r_chg_pend;
    logic        r_div_prev;

    state_t      w_nxt_state;
    logic        w_nxt_dir;
    logic [19:0] w_nxt_cnt;
    logic [25:0] w_nxt_wait;
    logic [1:0]  w_nxt_target;
    logic [1:0]  w_nxt_fast;
    logic        w_nxt_chg;

`ifdef SPEED_CTRL_AUTO_RETURN_EN
    logic [15:0] r_ret_cnt;
    logic [15:0] w_nxt_ret;
`else
    logic        w_unused_ret_edges;
    assign w_unused_ret_edges = ^RETURN_EDGES;
`endif

    sync2 u_sync_up  (.i_clk(clkin), .i_rst_n(rst_N), .i_d(btn_up),  .o_q(w_up));
    sync2 u_sync_dn  (.i_clk(clkin), .i_rst_n(rst_N), .i_d(btn_dn),  .o_q(w_dn));
    sync2 u_sync_div (.i_clk(clkin), .i_rst_n(rst_N), .i_d(div_clk), .o_q(w_div));

    assign w_div_fall = r_div_prev & ~w_div;
    assign w_btn_lat  = r_dir ? w_up : w_dn;
    assign w_tgt_calc = next_speed(r_fast, r_dir);

    // State and datapath registers; reset discards any pending change.
    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N) begin
            r_state    <= ST_IDLE;
            r_dir      <= 1'b0;
            r_cnt      <= '0;
            r_wait     <= '0;
            r_target   <= SPD_NORMAL;
            r_fast     <= SPD_NORMAL;
            r_chg_pend <= 1'b0;
            r_div_prev <= 1'b0;
`ifdef SPEED_CTRL_AUTO_RETURN_EN
            r_ret_cnt  <= '0;
`endif
        end else begin
            r_state    <= w_nxt_state;
            r_dir      <= w_nxt_dir;
            r_cnt      <= w_nxt_cnt;
            r_wait     <= w_nxt_wait;
            r_target   <= w_nxt_target;
            r_fast     <= w_nxt_fast;
            r_chg_pend <= w_nxt_chg;
            r_div_prev <= w_div;
`ifdef SPEED_CTRL_AUTO_RETURN_EN
            r_ret_cnt  <= w_nxt_ret;
`endif
        end
    end

    // Next-state and next-datapath decode; fast is only updated in APPLY.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_dir    = r_dir;
        w_nxt_cnt    = r_cnt;
        w_nxt_wait   = r_wait;
        w_nxt_target = r_target;
        w_nxt_fast   = r_fast;
        w_nxt_chg    = r_chg_pend;
`ifdef SPEED_CTRL_AUTO_RETURN_EN
        w_nxt_ret    = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_nxt_cnt  = '0;
                w_nxt_wait = '0;
                // A single button wins over auto-return; both pressed is ambiguous.
                if (w_up ^ w_dn) begin
                    w_nxt_dir   = w_up;
                    w_nxt_state = ST_DEBOUNCE;
                end
`ifdef SPEED_CTRL_AUTO_RETURN_EN
                else if (r_fast != SPD_NORMAL) begin
                    if (w_div_fall) begin
                        if (r_ret_cnt == RETURN_EDGES - 16'd1) begin
                            // Edge just seen, so skip WAIT_EDGE and apply directly.
                            w_nxt_target = SPD_NORMAL;
                            w_nxt_chg    = 1'b1;
                            w_nxt_state  = ST_APPLY;
                        end else begin
                            w_nxt_ret = r_ret_cnt + 16'd1;
                        end
                    end else begin
                        w_nxt_ret = r_ret_cnt;
                    end
                end
`endif
            end
            ST_DEBOUNCE: begin
                if (w_btn_lat) begin
                    if (r_cnt == DEBOUNCE_CYC - 20'd1) begin
                        w_nxt_cnt = '0;
                        if (w_tgt_calc == r_fast) begin
                            w_nxt_state = ST_RELEASE;
                        end else begin
                            w_nxt_target = w_tgt_calc;
                            w_nxt_chg    = 1'b1;
                            w_nxt_wait   = '0;
                            w_nxt_state  = ST_WAIT_EDGE;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 20'd1;
                    end
                end else begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_WAIT_EDGE: begin
                if (w_div_fall || (r_wait == WAIT_MAX - 26'd1)) begin
                    w_nxt_wait  = '0;
                    w_nxt_state = ST_APPLY;
                end else begin
                    w_nxt_wait = r_wait + 26'd1;
                end
            end
            ST_APPLY: begin
                w_nxt_fast  = r_target;
                w_nxt_chg   = 1'b0;
                w_nxt_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!w_up && !w_dn) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    assign fast     = r_fast;
    assign chg_pend = r_chg_pend;

endmodule
